mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the five-stage pipeline: latches the EX-stage result and control, runs the data-memory request/acknowledge handshake, and aligns and extends load data. Its WB_* outputs drive the WB pipeline register directly. While a memory access is outstanding it stalls the upstream stages and presents a bubble to WB. WB has no enable, so every cycle must carry either a retiring instruction or a bubble.

## Interface
- DATA_W, 32, datapath width.
- TIMEOUT_CYC, 16, watchdog limit in cycles; used only with MEM_STAGE_TIMEOUT_EN.
- CLK  in  1  clock. Everything samples on its rising edge.
- RST  in  1  synchronous, active-high reset.
- EX_VALID_IN  in  1  EX holds a real instruction.
- EX_RF_WE_IN, EX_MREWR_MUX_IN[1:0], EX_NUMINSTADD_IN  in  1/2/1  write-back control to pass through.
- EX_MEM_RD_IN, EX_MEM_WR_IN  in  1/1  load or store. Both high is illegal and is treated as a store.
- EX_FUNCT3_IN  in  3  access size and signedness: LB=0, LH=1, LW=2, LBU=4, LHU=5.
- EX_ALU_IN  in  DATA_W  ALU result, which is also the memory address.
- EX_WDATA_IN  in  DATA_W  store data, unaligned.
- FLUSH_IN  in  1  kill the latched instruction.
- STALL_OUT  out  1  upstream must hold.
- D_MEM_REQ_OUT, D_MEM_WEN_OUT  out  1/1  request; WEN=1 means write.
- D_MEM_ADDR_OUT  out  DATA_W  word-aligned address (low 2 bits zero).
- D_MEM_BE_OUT  out  4  byte enables.
- D_MEM_WDATA_OUT  out  DATA_W  store data shifted to its byte lane.
- D_MEM_ACK_IN  in  1  access complete.
- D_MEM_RDATA_IN  in  DATA_W  read data, valid when ACK=1.
- WB_RF_WE_OUT, WB_MREWR_MUX_OUT[1:0], WB_NUMINSTADD_OUT  out  1/2/1  to the WB register.
- WB_LOAD_DATA_OUT, WB_ALU_OUT  out  DATA_W  load result and forwarded ALU result.
- MEM_ERR_OUT  out  1  sticky error flag.

## Operation
- **Latch.** Fields are latched at each edge where STALL_OUT=0. A latched FLUSH_IN or EX_VALID_IN=0 produces valid=0.
- **States.** IDLE and WAIT, held in a two-state FSM.
  - IDLE→WAIT: at a latch edge that captures a valid load or store.
  - WAIT→IDLE: at an edge where D_MEM_ACK_IN=1 (or on timeout).
- **Request outputs.** D_MEM_REQ_OUT = (state==WAIT). Address, BE, WEN and WDATA come from the latched fields and are held stable for the whole of WAIT.
- **Byte enables.**
  - Byte access: one bit at addr[1:0].
  - Halfword access: 0011 or 1100, selected by addr[1].
  - Word access: 1111.
  - Misaligned halfword or word: no request is issued. The instruction retires as a bubble and MEM_ERR_OUT is set.
- **Load alignment.** Select the byte lane(s) given by addr[1:0], then sign-extend (LB, LH) or zero-extend (LBU, LHU) to DATA_W.
- **WB outputs.**
  - A valid non-memory instruction in IDLE drives the latched control values.
  - A memory instruction drives control values only in the WAIT cycle with ACK=1.
  - Every other cycle drives the bubble RF_WE=0, NUMINSTADD=0, MREWR_MUX=0.
- **Stall.** STALL_OUT = (state==WAIT) & ~D_MEM_ACK_IN.
- **Flush.**
  - In IDLE: valid is cleared at the next edge.
  - In WAIT: the access runs to ACK (a store cannot be cancelled), but a kill bit suppresses retirement and the WB outputs show a bubble.
- **Reset.** Overrides everything, including WAIT mid-access. State goes to IDLE, all latches and the kill bit clear, and MEM_ERR_OUT clears.

## Timing
- **Reset values.** Every output is 0: WB_*, STALL_OUT, D_MEM_*, WB_LOAD_DATA_OUT, WB_ALU_OUT and MEM_ERR_OUT.
- **Non-memory instruction.** WB outputs are valid in the cycle after the latch edge.
- **Memory instruction.** Request is asserted in the cycle after the latch edge.
  - With ACK in that same cycle: zero stall, and WB outputs are valid that cycle.
  - Each cycle without ACK adds one stall cycle.
- **Back-to-back.** The next instruction latches on the edge that samples ACK=1, so loads issue back-to-back with no gap.
- **Stray ACK.** ACK while in IDLE is ignored.

## Configuration
- **MEM_STAGE_TIMEOUT_EN defined.**
  - A counter of width $clog2(TIMEOUT_CYC+1) starts at 0 on entry to WAIT and increments on each cycle in WAIT without ACK.
  - When the count reaches TIMEOUT_CYC the access is abandoned: state goes to IDLE, the instruction retires as a bubble, MEM_ERR_OUT is set, and STALL_OUT falls in that same cycle.
- **Undefined.** No counter is built, and WAIT persists indefinitely until ACK.

## Structure
- **Package mem_stage_pkg** holds:
  - the state enum;
  - the FUNCT3 size constants;
  - the MREWR_MUX encodings: ALU=0, MEM=1, PC4=2;
  - the bubble constant.
- **Sub-module load_align.** Purely combinational: address low bits, funct3 and raw data in; extended data out.

## Test plan
- **ALU pass-through.** Valid ALU op with RF_WE=1, MREWR=0, ALU=0x1234 → next cycle WB_RF_WE=1, WB_ALU_OUT=0x1234, STALL_OUT=0.
- **Signed byte load.** LB at addr 0x103, ACK after 3 cycles, RDATA=0x80FF_FF00 → STALL_OUT high for exactly 3 cycles, D_MEM_ADDR_OUT=0x100, BE=1000, WB_LOAD_DATA_OUT=0xFFFF_FF80 in the ACK cycle.
- **Halfword store.** SH at addr 0x2, data 0xABCD → BE=1100, D_MEM_WDATA_OUT=0xABCD_0000, WEN=1; WB_RF_WE=0.
- **Flush during WAIT.** FLUSH_IN while a load waits → request held until ACK, WB outputs remain a bubble, and the following instruction retires normally.
- **Misaligned word.** LW at addr 0x6 → no D_MEM_REQ_OUT, MEM_ERR_OUT=1, bubble on WB.
- **Timeout and reset.** With MEM_STAGE_TIMEOUT_EN and TIMEOUT_CYC=4, no ACK → STALL_OUT drops after 4 cycles and MEM_ERR_OUT=1. Asserting RST mid-WAIT → all outputs 0 next cycle.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// rtl/mem_stage_pkg.sv - shared types, encodings and access-size helpers for mem_stage
package mem_stage_pkg;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_WAIT = 1'b1
   } state_e;

   localparam logic [2:0] F3_LB  = 3'd0;
   localparam logic [2:0] F3_LH  = 3'd1;
   localparam logic [2:0] F3_LW  = 3'd2;
   localparam logic [2:0] F3_LBU = 3'd4;
   localparam logic [2:0] F3_LHU = 3'd5;

   localparam logic [1:0] MUX_ALU = 2'd0;
   localparam logic [1:0] MUX_MEM = 2'd1;
   localparam logic [1:0] MUX_PC4 = 2'd2;

   typedef struct packed {
      logic       rf_we;
      logic [1:0] mrewr_mux;
      logic       numinstadd;
   } wb_ctrl_t;

   localparam wb_ctrl_t WB_BUBBLE = '{rf_we: 1'b0, mrewr_mux: MUX_ALU, numinstadd: 1'b0};

   // size is funct3[1:0]; the unused code 3 behaves like a word access
   function automatic logic [3:0] byte_en(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         2'b00:   return 4'b0001 << addr_lo;
         2'b01:   return addr_lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

   function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
      case (size)
         2'b00:   return 1'b0;
         2'b01:   return addr_lo[0];
         default: return |addr_lo;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// rtl/load_align.sv - selects the addressed byte/halfword of read data and extends it
module load_align
   import mem_stage_pkg::*;
#(
   parameter int DATA_W = 32
) (
   input  logic [1:0]        addr_lo,
   input  logic [2:0]        funct3,
   input  logic [DATA_W-1:0] rdata,
   output logic [DATA_W-1:0] data
);

   logic [DATA_W-1:0] shifted;
   logic [7:0]        lane_b;
   logic [15:0]       lane_h;

   // misaligned accesses never reach here, so one byte-granular shift covers every size
   always_comb begin
      shifted = rdata >> {addr_lo, 3'b000};
      lane_b  = shifted[7:0];
      lane_h  = shifted[15:0];
      case (funct3)
         F3_LB:   data = {{(DATA_W-8){lane_b[7]}}, lane_b};
         F3_LH:   data = {{(DATA_W-16){lane_h[15]}}, lane_h};
         F3_LBU:  data = {{(DATA_W-8){1'b0}}, lane_b};
         F3_LHU:  data = {{(DATA_W-16){1'b0}}, lane_h};
         default: data = shifted;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// rtl/mem_stage.sv - MEM pipeline stage: data-memory handshake, stall and WB drive.
// Optional access watchdog is built when MEM_STAGE_TIMEOUT_EN is defined.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DATA_W      = 32,
   parameter int TIMEOUT_CYC = 16
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              EX_VALID_IN,
   input  logic              EX_RF_WE_IN,
   input  logic [1:0]        EX_MREWR_MUX_IN,
   input  logic              EX_NUMINSTADD_IN,
   input  logic              EX_MEM_RD_IN,
   input  logic              EX_MEM_WR_IN,
   input  logic [2:0]        EX_FUNCT3_IN,
   input  logic [DATA_W-1:0] EX_ALU_IN,
   input  logic [DATA_W-1:0] EX_WDATA_IN,
   input  logic              FLUSH_IN,
   output logic              STALL_OUT,
   output logic              D_MEM_REQ_OUT,
   output logic              D_MEM_WEN_OUT,
   output logic [DATA_W-1:0] D_MEM_ADDR_OUT,
   output logic [3:0]        D_MEM_BE_OUT,
   output logic [DATA_W-1:0] D_MEM_WDATA_OUT,
   input  logic              D_MEM_ACK_IN,
   input  logic [DATA_W-1:0] D_MEM_RDATA_IN,
   output logic              WB_RF_WE_OUT,
   output logic [1:0]        WB_MREWR_MUX_OUT,
   output logic              WB_NUMINSTADD_OUT,
   output logic [DATA_W-1:0] WB_LOAD_DATA_OUT,
   output logic [DATA_W-1:0] WB_ALU_OUT,
   output logic              MEM_ERR_OUT
);

   state_e            state_q, state_d;
   logic              valid_q, valid_d;
   wb_ctrl_t          ctrl_q, ctrl_d;
   logic              mem_q, mem_d;
   logic              wen_q, wen_d;
   logic [2:0]        funct3_q, funct3_d;
   logic [DATA_W-1:0] alu_q, alu_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              kill_q, kill_d;
   logic              err_q, err_d;

`ifdef MEM_STAGE_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

   logic              in_wait;
   logic              timeout;
   logic              stall;
   logic              ex_valid;
   logic              ex_mem;
   logic              ex_misal;
   wb_ctrl_t          wb_ctrl;
   logic [DATA_W-1:0] wdata_lane;
   logic [DATA_W-1:0] load_data;

   always_comb begin
      in_wait  = (state_q == ST_WAIT);
`ifdef MEM_STAGE_TIMEOUT_EN
      timeout  = in_wait & ~D_MEM_ACK_IN & (cnt_q == CNT_W'(TIMEOUT_CYC));
`else
      timeout  = 1'b0;
`endif
      stall    = in_wait & ~D_MEM_ACK_IN & ~timeout;
      ex_valid = EX_VALID_IN & ~FLUSH_IN;
      ex_mem   = EX_MEM_RD_IN | EX_MEM_WR_IN;
      ex_misal = is_misaligned(EX_FUNCT3_IN[1:0], EX_ALU_IN[1:0]);

      state_d  = state_q;
      valid_d  = valid_q;
      ctrl_d   = ctrl_q;
      mem_d    = mem_q;
      wen_d    = wen_q;
      funct3_d = funct3_q;
      alu_d    = alu_q;
      wdata_d  = wdata_q;
      kill_d   = kill_q;

      // every non-stalled edge is a latch edge, including the one that samples ACK
      if (!stall) begin
         valid_d  = ex_valid;
         ctrl_d   = '{rf_we: EX_RF_WE_IN, mrewr_mux: EX_MREWR_MUX_IN, numinstadd: EX_NUMINSTADD_IN};
         mem_d    = ex_mem;
         wen_d    = EX_MEM_WR_IN;
         funct3_d = EX_FUNCT3_IN;
         alu_d    = EX_ALU_IN;
         wdata_d  = EX_WDATA_IN;
         kill_d   = 1'b0;
         state_d  = (ex_valid & ex_mem & ~ex_misal) ? ST_WAIT : ST_IDLE;
      end else if (FLUSH_IN) begin
         kill_d   = 1'b1;
      end

      err_d = err_q | (~stall & ex_valid & ex_mem & ex_misal) | timeout;
`ifdef MEM_STAGE_TIMEOUT_EN
      cnt_d = stall ? cnt_q + CNT_W'(1) : '0;
`endif
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q  <= ST_IDLE;
         valid_q  <= 1'b0;
         ctrl_q   <= WB_BUBBLE;
         mem_q    <= 1'b0;
         wen_q    <= 1'b0;
         funct3_q <= '0;
         alu_q    <= '0;
         wdata_q  <= '0;
         kill_q   <= 1'b0;
         err_q    <= 1'b0;
`ifdef MEM_STAGE_TIMEOUT_EN
         cnt_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         valid_q  <= valid_d;
         ctrl_q   <= ctrl_d;
         mem_q    <= mem_d;
         wen_q    <= wen_d;
         funct3_q <= funct3_d;
         alu_q    <= alu_d;
         wdata_q  <= wdata_d;
         kill_q   <= kill_d;
         err_q    <= err_d;
`ifdef MEM_STAGE_TIMEOUT_EN
         cnt_q    <= cnt_d;
`endif
      end
   end

   always_comb begin
      case (funct3_q[1:0])
         2'b00:   wdata_lane = DATA_W'(wdata_q[7:0]) << {alu_q[1:0], 3'b000};
         2'b01:   wdata_lane = DATA_W'(wdata_q[15:0]) << {alu_q[1], 4'b0000};
         default: wdata_lane = wdata_q;
      endcase
   end

   load_align #(.DATA_W(DATA_W)) u_load_align (
      .addr_lo (alu_q[1:0]),
      .funct3  (funct3_q),
      .rdata   (D_MEM_RDATA_IN),
      .data    (load_data)
   );

   // WB has no enable: anything that is not retiring this cycle must look like a bubble
   always_comb begin
      wb_ctrl = WB_BUBBLE;
      if (!in_wait && valid_q && !mem_q) begin
         wb_ctrl = ctrl_q;
      end else if (in_wait && D_MEM_ACK_IN && !kill_q) begin
         wb_ctrl = ctrl_q;
      end
   end

   always_comb begin
      STALL_OUT         = stall;
      D_MEM_REQ_OUT     = in_wait;
      D_MEM_WEN_OUT     = in_wait & wen_q;
      D_MEM_ADDR_OUT    = in_wait ? {alu_q[DATA_W-1:2], 2'b00} : '0;
      D_MEM_BE_OUT      = in_wait ? byte_en(funct3_q[1:0], alu_q[1:0]) : 4'b0000;
      D_MEM_WDATA_OUT   = in_wait ? wdata_lane : '0;
      WB_RF_WE_OUT      = wb_ctrl.rf_we;
      WB_MREWR_MUX_OUT  = wb_ctrl.mrewr_mux;
      WB_NUMINSTADD_OUT = wb_ctrl.numinstadd;
      WB_LOAD_DATA_OUT  = (in_wait & D_MEM_ACK_IN) ? load_data : '0;
      WB_ALU_OUT        = alu_q;
      MEM_ERR_OUT       = err_q;
   end

endmodule

// File: tb/tb_mem_stage.sv
// tb/tb_mem_stage.sv - randomized self-checking bench for mem_stage against a behavioural model
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        ex_valid, ex_rf_we, ex_numinst, ex_mem_rd, ex_mem_wr, flush;
   logic [1:0]  ex_mrewr;
   logic [2:0]  ex_funct3;
   logic [31:0] ex_alu, ex_wdata;
   logic        stall, req, wen, ack;
   logic [31:0] addr, wdata, rdata;
   logic [3:0]  be;
   logic        wb_rf_we, wb_numinst, mem_err;
   logic [1:0]  wb_mrewr;
   logic [31:0] wb_load, wb_alu;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mem_stage #(.DATA_W(32), .TIMEOUT_CYC(4)) dut (
      .CLK(clk), .RST(rst),
      .EX_VALID_IN(ex_valid), .EX_RF_WE_IN(ex_rf_we), .EX_MREWR_MUX_IN(ex_mrewr),
      .EX_NUMINSTADD_IN(ex_numinst), .EX_MEM_RD_IN(ex_mem_rd), .EX_MEM_WR_IN(ex_mem_wr),
      .EX_FUNCT3_IN(ex_funct3), .EX_ALU_IN(ex_alu), .EX_WDATA_IN(ex_wdata), .FLUSH_IN(flush),
      .STALL_OUT(stall), .D_MEM_REQ_OUT(req), .D_MEM_WEN_OUT(wen), .D_MEM_ADDR_OUT(addr),
      .D_MEM_BE_OUT(be), .D_MEM_WDATA_OUT(wdata), .D_MEM_ACK_IN(ack), .D_MEM_RDATA_IN(rdata),
      .WB_RF_WE_OUT(wb_rf_we), .WB_MREWR_MUX_OUT(wb_mrewr), .WB_NUMINSTADD_OUT(wb_numinst),
      .WB_LOAD_DATA_OUT(wb_load), .WB_ALU_OUT(wb_alu), .MEM_ERR_OUT(mem_err)
   );

   function automatic int size_of(input logic [2:0] f3);
      if (f3 == 3'd0 || f3 == 3'd4) return 1;
      if (f3 == 3'd1 || f3 == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
      int mask;
      mask = ((1 << size_of(f3)) - 1) << (a % 4);
      return 4'(mask);
   endfunction

   function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      longint unsigned v;
      v = longint'(wd) % (64'd1 << (8 * size_of(f3)));
      return 32'(v << (8 * (a % 4)));
   endfunction

   function automatic logic [31:0] exp_load(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] rd);
      longint v;
      v = longint'(rd >> (8 * (a % 4)));
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
         3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
         3'd4: v = v % 256;
         3'd5: v = v % 65536;
         default: v = longint'(rd);
      endcase
      return 32'(v);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic ex_clear();
      ex_valid = 0; ex_rf_we = 0; ex_mrewr = 0; ex_numinst = 0;
      ex_mem_rd = 0; ex_mem_wr = 0; flush = 0;
   endtask

   task automatic ex_mem_op(input logic is_store, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
      ex_valid = 1; ex_rf_we = ~is_store; ex_mrewr = is_store ? 2'd0 : 2'd1; ex_numinst = 1;
      ex_mem_rd = ~is_store; ex_mem_wr = is_store; ex_funct3 = f3; ex_alu = a; ex_wdata = wd;
   endtask

   task automatic test_reset();
      rst = 1; ack = 0; rdata = 32'hDEAD_BEEF; ex_clear(); ex_funct3 = 0; ex_alu = 0; ex_wdata = 0;
      tick(); tick();
      @(negedge clk);
      n_checks++;
      if ({stall, req, wen, addr, be, wdata, wb_rf_we, wb_mrewr, wb_numinst, wb_load, wb_alu, mem_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got req=%b stall=%b wb_rf_we=%b alu=%h err=%b, want all zero",
                  req, stall, wb_rf_we, wb_alu, mem_err);
      end
      rst = 0;
      tick();
   endtask

   task automatic test_alu_passthrough();
      for (int it = 0; it < 8; it++) begin
         logic        we, ni;
         logic [1:0]  mx;
         logic [31:0] a;
         we = (it == 0) ? 1'b1 : 1'($urandom);
         ni = 1'($urandom);
         mx = (it == 0) ? 2'd0 : (($urandom % 2) ? 2'd2 : 2'd0);
         a  = (it == 0) ? 32'h1234 : $urandom;
         ex_clear(); ex_valid = 1; ex_rf_we = we; ex_mrewr = mx; ex_numinst = ni;
         ex_funct3 = 3'($urandom); ex_alu = a;
         tick();
         ex_clear();
         @(negedge clk);
         n_checks++;
         if ({wb_rf_we, wb_mrewr, wb_numinst, wb_alu} !== {we, mx, ni, a}) begin
            n_fail++;
            $display("FAIL alu_wb: got we=%b mux=%0d ni=%b alu=%h want we=%b mux=%0d ni=%b alu=%h",
                     wb_rf_we, wb_mrewr, wb_numinst, wb_alu, we, mx, ni, a);
         end
         n_checks++;
         if ({stall, req} !== 2'b00) begin
            n_fail++;
            $display("FAIL alu_no_stall: got stall=%b req=%b want 0 0", stall, req);
         end
         tick();
         @(negedge clk);
         n_checks++;
         if ({wb_rf_we, wb_numinst} !== 2'b00) begin
            n_fail++;
            $display("FAIL alu_single_retire: got we=%b ni=%b want 0 0", wb_rf_we, wb_numinst);
         end
         tick();
      end
   endtask

   task automatic test_load();
      logic [2:0] f3s [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      for (int it = 0; it < 12; it++) begin
         logic [2:0]  f3;
         logic [31:0] a, rd;
         int          dly, stalls;
         if (it == 0) begin
            f3 = 3'd0; a = 32'h103; rd = 32'h80FF_FF00; dly = 3;
         end else begin
            f3  = f3s[$urandom_range(0, 4)];
            a   = $urandom & ~(32'(size_of(f3)) - 32'd1);
            rd  = $urandom;
            dly = $urandom_range(0, 3);
         end
         ex_mem_op(1'b0, f3, a, $urandom);
         tick();
         ex_clear();
         stalls = 0;
         for (int k = 0; k <= dly; k++) begin
            ack   = (k == dly);
            rdata = (k == dly) ? rd : $urandom;
            @(negedge clk);
            if (stall) stalls++;
            n_checks++;
            if ({req, wen, addr, be} !== {1'b1, 1'b0, a & ~32'd3, exp_be(f3, a)}) begin
               n_fail++;
               $display("FAIL load_req: got req=%b wen=%b addr=%h be=%b want 1 0 %h %b",
                        req, wen, addr, be, a & ~32'd3, exp_be(f3, a));
            end
            if (k == dly) begin
               n_checks++;
               if ({wb_rf_we, wb_mrewr, wb_numinst, wb_load} !== {1'b1, 2'd1, 1'b1, exp_load(f3, a, rd)}) begin
                  n_fail++;
                  $display("FAIL load_wb: f3=%0d addr=%h got we=%b mux=%0d data=%h want 1 1 %h",
                           f3, a, wb_rf_we, wb_mrewr, wb_load, exp_load(f3, a, rd));
               end
            end else begin
               n_checks++;
               if (wb_rf_we !== 1'b0) begin
                  n_fail++;
                  $display("FAIL load_wait_bubble: got we=%b want 0", wb_rf_we);
               end
            end
            tick();
         end
         ack = 0;
         @(negedge clk);
         n_checks++;
         if (stalls !== dly) begin
            n_fail++;
            $display("FAIL load_stall_cycles: got %0d want %0d", stalls, dly);
         end
         n_checks++;
         if (req !== 1'b0) begin
            n_fail++;
            $display("FAIL load_req_drop: got %b want 0", req);
         end
         tick();
      end
   endtask

   task automatic test_store();
      for (int it = 0; it < 8; it++) begin
         logic [2:0]  f3;
         logic [31:0] a, wd;
         int          dly;
         if (it == 0) begin
            f3 = 3'd1; a = 32'h2; wd = 32'h0000_ABCD; dly = 1;
         end else begin
            f3  = 3'($urandom_range(0, 2));
            a   = $urandom & ~(32'(size_of(f3)) - 32'd1);
            wd  = $urandom;
            dly = $urandom_range(0, 2);
         end
         ex_mem_op(1'b1, f3, a, wd);
         tick();
         ex_clear();
         for (int k = 0; k <= dly; k++) begin
            ack = (k == dly);
            rdata = $urandom;
            @(negedge clk);
            n_checks++;
            if ({req, wen, addr, be, wdata} !== {1'b1, 1'b1, a & ~32'd3, exp_be(f3, a), exp_wdata(f3, a, wd)}) begin
               n_fail++;
               $display("FAIL store_req: got wen=%b addr=%h be=%b wdata=%h want 1 %h %b %h",
                        wen, addr, be, wdata, a & ~32'd3, exp_be(f3, a), exp_wdata(f3, a, wd));
            end
            n_checks++;
            if (wb_rf_we !== 1'b0) begin
               n_fail++;
               $display("FAIL store_rf_we: got %b want 0", wb_rf_we);
            end
            tick();
         end
         ack = 0;
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] a0, a1, r0, r1;
      a0 = $urandom & ~32'd3; a1 = $urandom & ~32'd3; r0 = $urandom; r1 = $urandom;
      ex_mem_op(1'b0, 3'd2, a0, 0);
      tick();
      ex_mem_op(1'b0, 3'd2, a1, 0);
      ack = 1; rdata = r0;
      @(negedge clk);
      n_checks++;
      if ({stall, wb_rf_we, wb_load} !== {1'b0, 1'b1, r0}) begin
         n_fail++;
         $display("FAIL b2b_first: got stall=%b we=%b data=%h want 0 1 %h", stall, wb_rf_we, wb_load, r0);
      end
      tick();
      ex_clear(); rdata = r1;
      @(negedge clk);
      n_checks++;
      if ({req, addr, wb_rf_we, wb_load} !== {1'b1, a1, 1'b1, r1}) begin
         n_fail++;
         $display("FAIL b2b_second: got req=%b addr=%h we=%b data=%h want 1 %h 1 %h",
                  req, addr, wb_rf_we, wb_load, a1, r1);
      end
      tick();
      ack = 0;
      @(negedge clk);
      n_checks++;
      if (req !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_idle: got req=%b want 0", req);
      end
      tick();
   endtask

   task automatic test_flush();
      logic [31:0] a, na;
      a = 32'h200; na = $urandom;
      ex_clear(); ex_valid = 1; ex_rf_we = 1; ex_numinst = 1; ex_alu = na; flush = 1;
      tick();
      ex_clear();
      @(negedge clk);
      n_checks++;
      if ({wb_rf_we, wb_numinst} !== 2'b00) begin
         n_fail++;
         $display("FAIL flush_idle: got we=%b ni=%b want 0 0", wb_rf_we, wb_numinst);
      end
      tick();
      ex_mem_op(1'b0, 3'd2, a, 0);
      tick();
      ex_clear(); flush = 1; ack = 0;
      for (int k = 0; k < 3; k++) begin
         ack = (k == 2); rdata = $urandom;
         @(negedge clk);
         n_checks++;
         if ({req, addr} !== {1'b1, a}) begin
            n_fail++;
            $display("FAIL flush_req_held: cycle %0d got req=%b addr=%h want 1 %h", k, req, addr, a);
         end
         n_checks++;
         if ({wb_rf_we, wb_mrewr, wb_numinst} !== 4'b0000) begin
            n_fail++;
            $display("FAIL flush_bubble: cycle %0d got we=%b mux=%0d ni=%b want 0", k, wb_rf_we, wb_mrewr, wb_numinst);
         end
         tick();
         flush = 0;
      end
      ack = 0;
      ex_clear(); ex_valid = 1; ex_rf_we = 1; ex_numinst = 1; ex_alu = na;
      tick();
      ex_clear();
      @(negedge clk);
      n_checks++;
      if ({wb_rf_we, wb_numinst, wb_alu} !== {2'b11, na}) begin
         n_fail++;
         $display("FAIL flush_next_retires: got we=%b ni=%b alu=%h want 1 1 %h", wb_rf_we, wb_numinst, wb_alu, na);
      end
      tick();
   endtask

   task automatic test_stray_ack();
      ex_clear(); ack = 1; rdata = $urandom;
      @(negedge clk);
      n_checks++;
      if ({req, stall, wb_rf_we} !== 3'b000) begin
         n_fail++;
         $display("FAIL stray_ack: got req=%b stall=%b we=%b want 0 0 0", req, stall, wb_rf_we);
      end
      tick();
      ack = 0;
      @(negedge clk);
      n_checks++;
      if (req !== 1'b0) begin
         n_fail++;
         $display("FAIL stray_ack_idle: got req=%b want 0", req);
      end
      tick();
   endtask

   task automatic test_misaligned();
      for (int it = 0; it < 3; it++) begin
         logic [2:0]  f3;
         logic [31:0] a;
         f3 = (it == 0) ? 3'd2 : 3'd1;
         a  = (it == 0) ? 32'h6 : ($urandom | 32'd1);
         ex_mem_op(1'b0, f3, a, 0);
         tick();
         ex_clear();
         @(negedge clk);
         n_checks++;
         if ({req, stall, wb_rf_we, wb_numinst, mem_err} !== 5'b00001) begin
            n_fail++;
            $display("FAIL misaligned: f3=%0d addr=%h got req=%b stall=%b we=%b ni=%b err=%b want 0 0 0 0 1",
                     f3, a, req, stall, wb_rf_we, wb_numinst, mem_err);
         end
         rst = 1;
         tick();
         rst = 0;
         @(negedge clk);
         n_checks++;
         if (mem_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_cleared_by_reset: got %b want 0", mem_err);
         end
         tick();
      end
   endtask

`ifdef MEM_STAGE_TIMEOUT_EN
   task automatic test_timeout();
      int highs;
      bit dropped;
      ex_mem_op(1'b0, 3'd2, 32'h40, 0); ack = 0;
      tick();
      ex_clear();
      highs = 0; dropped = 0;
      for (int k = 0; k < 20 && !dropped; k++) begin
         @(negedge clk);
         if (stall) highs++;
         else begin
            dropped = 1;
            n_checks++;
            if ({req, wb_rf_we} !== 2'b10) begin
               n_fail++;
               $display("FAIL timeout_abandon_cycle: got req=%b we=%b want 1 0", req, wb_rf_we);
            end
         end
         tick();
      end
      n_checks++;
      if (!dropped || highs != 4) begin
         n_fail++;
         $display("FAIL timeout_stall_cycles: got %0d (dropped=%0d) want 4", highs, dropped);
      end
      @(negedge clk);
      n_checks++;
      if ({mem_err, req, stall} !== 3'b100) begin
         n_fail++;
         $display("FAIL timeout_after: got err=%b req=%b stall=%b want 1 0 0", mem_err, req, stall);
      end
      rst = 1;
      tick();
      rst = 0;
   endtask
`endif

   task automatic test_reset_mid_wait();
      ex_mem_op(1'b0, 3'd2, 32'h1000, 0); ack = 0;
      tick();
      ex_clear();
      @(negedge clk);
      n_checks++;
      if (req !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_wait_entered: got req=%b want 1", req);
      end
      tick();
      rst = 1; ack = 1; rdata = $urandom | 32'd1;
      ex_valid = 1; ex_rf_we = 1; ex_numinst = 1; ex_alu = $urandom;
      tick();
      @(negedge clk);
      n_checks++;
      if ({stall, req, wen, addr, be, wdata, wb_rf_we, wb_mrewr, wb_numinst, wb_load, wb_alu, mem_err} !== '0) begin
         n_fail++;
         $display("FAIL reset_mid_wait: got req=%b stall=%b we=%b load=%h alu=%h err=%b want all zero",
                  req, stall, wb_rf_we, wb_load, wb_alu, mem_err);
      end
      rst = 0; ack = 0; ex_clear();
      tick();
      @(negedge clk);
      n_checks++;
      if ({req, stall} !== 2'b00) begin
         n_fail++;
         $display("FAIL reset_mid_wait_idle: got req=%b stall=%b want 0 0", req, stall);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_alu_passthrough();
      test_load();
      test_store();
      test_back_to_back();
      test_flush();
      test_stray_ack();
      test_misaligned();
`ifdef MEM_STAGE_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid_wait();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
